// File: rtl/lcd_reader.sv
// Read engine for the 4-bit HD44780 bus: one RW=1 byte read as two E pulses,
// high nibble first, with an optional busy-flag poll loop on RS=0 reads.
`timescale 1ns/1ps
module lcd_reader #(
    parameter int FREQ      = 50000000,
    parameter int SETUP_CYC = FREQ / 1000000 * 1,
    parameter int EHIGH_CYC = FREQ / 1000000 * 3,
    parameter int ELOW_CYC  = FREQ / 1000000 * 1,
    parameter int MAX_POLLS = 255
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       readStart,
    input  logic       read_rs,
    input  logic       pollBusy,
    input  logic [3:0] LCD_D_IN,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       bus_release,
    output logic [7:0] readData,
    output logic       readDone,
    output logic       timeout,
    output logic       ready
);

    localparam int MAX_CYC = (SETUP_CYC > EHIGH_CYC) ?
                             ((SETUP_CYC > ELOW_CYC) ? SETUP_CYC : ELOW_CYC) :
                             ((EHIGH_CYC > ELOW_CYC) ? EHIGH_CYC : ELOW_CYC);
    localparam int TW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE, SETUP, EH_HI, EL_HI, EH_LO, EL_LO, CHECK, DONE
    } state_t;

    state_t        state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [TW-1:0] span_last;
    logic          timer_last;
    logic [7:0]    poll_cnt_reg, poll_cnt_next;
    logic          rs_lat_reg, rs_lat_next;
    logic          poll_lat_reg, poll_lat_next;
    logic [7:0]    data_next;
    logic          timeout_next;
    logic          poll_more;
    logic          rw_next;

    always_comb begin
        span_last = '0;
        case (state_reg)
            SETUP:        span_last = TW'(SETUP_CYC - 1);
            EH_HI, EH_LO: span_last = TW'(EHIGH_CYC - 1);
            EL_HI, EL_LO: span_last = TW'(ELOW_CYC - 1);
            default:      span_last = '0;
        endcase
        timer_last = (timer_reg == span_last);
    end

    // A repeat poll is decided at the end of EL_LO so back-to-back reads are
    // exactly two E periods apart; CHECK only handles the final byte.
    assign poll_more = poll_lat_reg && readData[7] &&
                       (({24'd0, poll_cnt_reg} + 32'd1) < 32'(MAX_POLLS));

    always_comb begin
        state_next    = state_reg;
        rs_lat_next   = rs_lat_reg;
        poll_lat_next = poll_lat_reg;
        poll_cnt_next = poll_cnt_reg;
        data_next     = readData;
        timeout_next  = timeout;
        case (state_reg)
            IDLE: begin
                if (readStart) begin
                    state_next    = SETUP;
                    rs_lat_next   = read_rs;
                    poll_lat_next = pollBusy & ~read_rs;
                    poll_cnt_next = 8'd0;
                    timeout_next  = 1'b0;
                end
            end
            SETUP: if (timer_last) state_next = EH_HI;
            EH_HI: begin
                if (timer_last) begin
                    data_next[7:4] = LCD_D_IN;
                    state_next     = EL_HI;
                end
            end
            EL_HI: if (timer_last) state_next = EH_LO;
            EH_LO: begin
                if (timer_last) begin
                    data_next[3:0] = LCD_D_IN;
                    state_next     = EL_LO;
                end
            end
            EL_LO: begin
                if (timer_last) begin
                    if (poll_more) begin
                        poll_cnt_next = poll_cnt_reg + 8'd1;
                        state_next    = EH_HI;
                    end else begin
                        state_next = CHECK;
                    end
                end
            end
            CHECK: begin
                if (poll_lat_reg && readData[7]) timeout_next = 1'b1;
                state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (state_next != state_reg || state_reg == IDLE) timer_next = '0;
        else                                               timer_next = timer_reg + TW'(1);

        rw_next = (state_next inside {SETUP, EH_HI, EL_HI, EH_LO, EL_LO, CHECK});
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            poll_cnt_reg <= 8'd0;
            rs_lat_reg   <= 1'b0;
            poll_lat_reg <= 1'b0;
            LCD_E        <= 1'b0;
            LCD_RS       <= 1'b0;
            LCD_RW       <= 1'b0;
            bus_release  <= 1'b0;
            readData     <= 8'd0;
            readDone     <= 1'b0;
            timeout      <= 1'b0;
            ready        <= 1'b1;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            poll_cnt_reg <= poll_cnt_next;
            rs_lat_reg   <= rs_lat_next;
            poll_lat_reg <= poll_lat_next;
            LCD_E        <= (state_next == EH_HI) || (state_next == EH_LO);
            LCD_RS       <= rw_next & rs_lat_next;
            LCD_RW       <= rw_next;
            bus_release  <= rw_next;
            readData     <= data_next;
            readDone     <= (state_next == DONE);
            timeout      <= timeout_next;
            ready        <= (state_next == IDLE);
        end
    end

endmodule
